// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : io_pkg
// Brief   : Shared constants for the CPU I/O input controller register map.
// Rev     : 1.0 - initial release
// ============================================================================
package io_pkg;

  localparam int         IO_DATA_W    = 16;

  localparam logic [1:0] IO_ADDR_BTN  = 2'd0;
  localparam logic [1:0] IO_ADDR_SW   = 2'd1;
  localparam logic [1:0] IO_ADDR_PEND = 2'd2;
  localparam logic [1:0] IO_ADDR_MASK = 2'd3;

endpackage : io_pkg
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
// Module  : debounce_cell
// Brief   : Two-flop synchroniser plus counter debounce for one active-low button.
// Rev     : 1.0 - initial release
// ============================================================================
module debounce_cell #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_n,
  output logic level,
  output logic press
);

  localparam int            CW     = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1_n;
  logic          r_sync2_n;
  logic          r_stable_n;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;

  assign w_differ = (r_sync2_n != r_stable_n);
  assign w_accept = w_differ && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1_n  <= 1'b1;
      r_sync2_n  <= 1'b1;
      r_stable_n <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_sync1_n <= din_n;
      r_sync2_n <= r_sync1_n;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable_n <= r_sync2_n;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = ~r_stable_n;
  // Combinational so the pending bit can set on the same edge stable flips.
  assign press = w_accept & ~r_sync2_n;

endmodule : debounce_cell
`default_nettype wire

// File: rtl/io_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : io_input_ctrl
// Brief   : Button/switch input controller with sticky press events and IRQ.
// Rev     : 1.0 - initial release
// ============================================================================
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int N_SW      = 10,
  parameter int DB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BTN-1:0]     buttons,
  input  logic [N_SW-1:0]      switches,
  input  logic [1:0]           addr,
  input  logic                 re,
  input  logic                 we,
  input  logic [IO_DATA_W-1:0] wdata,
  output logic [IO_DATA_W-1:0] rdata,
  output logic                 irq
);

  logic [N_BTN-1:0]     w_btn_level;
  logic [N_BTN-1:0]     w_btn_press;
  logic [N_SW-1:0]      r_sw_sync1;
  logic [N_SW-1:0]      r_sw_sync2;
  logic [N_BTN-1:0]     r_pending;
  logic [N_BTN-1:0]     r_mask;
  logic [N_BTN-1:0]     w_clr;
  logic                 w_wr_pend;
  logic                 w_wr_mask;
  logic [IO_DATA_W-1:0] w_rd_mux;
  logic [IO_DATA_W-1:0] r_rdata;
  logic                 r_irq;
  logic                 w_unused_wdata;

  assign w_unused_wdata = ^wdata;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .din_n (buttons[i]),
      .level (w_btn_level[i]),
      .press (w_btn_press[i])
    );
  end

  assign w_wr_pend = we && (addr == IO_ADDR_PEND);
  assign w_wr_mask = we && (addr == IO_ADDR_MASK);
  assign w_clr     = w_wr_pend ? wdata[N_BTN-1:0] : '0;

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      IO_ADDR_BTN:  w_rd_mux[N_BTN-1:0] = w_btn_level;
      IO_ADDR_SW:   w_rd_mux[N_SW-1:0]  = r_sw_sync2;
      IO_ADDR_PEND: w_rd_mux[N_BTN-1:0] = r_pending;
      IO_ADDR_MASK: w_rd_mux[N_BTN-1:0] = r_mask;
      default:      w_rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_rdata    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sw_sync1 <= switches;
      r_sw_sync2 <= r_sw_sync1;
      // A new press outranks a same-cycle W1C of that bit.
      r_pending  <= (r_pending & ~w_clr) | w_btn_press;
      if (w_wr_mask) begin
        r_mask <= wdata[N_BTN-1:0];
      end
      if (re) begin
        r_rdata <= w_rd_mux;
      end
      r_irq <= |(r_pending & r_mask);
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule : io_input_ctrl
`default_nettype wire

// File: tb/tb_io_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_io_input_ctrl
// Brief   : Vector-table and directed-sequence bench for io_input_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_io_input_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  buttons;
  logic [9:0]  switches;
  logic [1:0]  addr;
  logic        re;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  btn;
    logic [9:0]  sw;
    logic [1:0]  addr;
    logic        re;
    logic        we;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  io_input_ctrl #(
    .N_BTN     (4),
    .N_SW      (10),
    .DB_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .buttons  (buttons),
    .switches (switches),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #30 clk = ~clk;

  initial begin
    #(60 * 5000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string n, logic [3:0] b, logic [9:0] s, logic [1:0] a,
                              logic r, logic w, logic [15:0] d,
                              logic c, logic [15:0] er, logic ei);
    vec_t v;
    v.name = n; v.btn = b; v.sw = s; v.addr = a; v.re = r; v.we = w;
    v.wdata = d; v.chk_rd = c; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One bus cycle: drive strobes for a single edge, then release them.
  task automatic bus(logic [1:0] a, logic r, logic w, logic [15:0] d);
    addr = a; re = r; we = w; wdata = d;
    step();
    re = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(string name, logic [1:0] a, logic [15:0] exp);
    bus(a, 1'b1, 1'b0, 16'h0000);
    chk(name, rdata, exp);
  endtask

  initial begin
    reset = 1'b0; buttons = 4'b1111; switches = '0;
    addr = 2'd0; re = 1'b0; we = 1'b0; wdata = '0;

    // Reset held for two edges
    idle(2);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    reset = 1'b1;

    tbl.push_back(mk("rd_btn_after_reset",  4'hF, 10'h000, 2'd0, 1, 0, 16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk("rd_pend_after_reset", 4'hF, 10'h000, 2'd2, 1, 0, 16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk("rd_mask_after_reset", 4'hF, 10'h000, 2'd3, 1, 0, 16'h0000, 1, 16'h0000, 0));
    // Button 0 pressed from edge 1; stable/pending flip at edge 6
    tbl.push_back(mk("press_e1",            4'hE, 10'h000, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk("press_e2",            4'hE, 10'h000, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk("press_e3",            4'hE, 10'h000, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk("press_e4",            4'hE, 10'h000, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk("btn_before_e5",       4'hE, 10'h000, 2'd0, 1, 0, 16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk("pend_before_e6",      4'hE, 10'h000, 2'd2, 1, 0, 16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk("btn_after_e6",        4'hE, 10'h000, 2'd0, 1, 0, 16'h0000, 1, 16'h0001, 0));
    tbl.push_back(mk("pend_after_e6",       4'hE, 10'h000, 2'd2, 1, 0, 16'h0000, 1, 16'h0001, 0));
    tbl.push_back(mk("mask_wr_read_old",    4'hE, 10'h000, 2'd3, 1, 1, 16'h000F, 1, 16'h0000, 0));
    tbl.push_back(mk("irq_after_mask",      4'hE, 10'h000, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 1));
    tbl.push_back(mk("rd_mask_new",         4'hE, 10'h000, 2'd3, 1, 0, 16'h0000, 1, 16'h000F, 1));
    // Switches: two-edge synchroniser
    tbl.push_back(mk("sw_e1",               4'hE, 10'h155, 2'd0, 0, 0, 16'h0000, 0, 16'h0000, 1));
    tbl.push_back(mk("sw_before_e2",        4'hE, 10'h155, 2'd1, 1, 0, 16'h0000, 1, 16'h0000, 1));
    tbl.push_back(mk("sw_after_e2",         4'hE, 10'h155, 2'd1, 1, 0, 16'h0000, 1, 16'h0155, 1));
    tbl.push_back(mk("sw_wr_ignored_rd",    4'hE, 10'h155, 2'd1, 1, 1, 16'hFFFF, 1, 16'h0155, 1));
    tbl.push_back(mk("sw_after_wr",         4'hE, 10'h155, 2'd1, 1, 0, 16'h0000, 1, 16'h0155, 1));
    tbl.push_back(mk("rdata_hold_no_re",    4'hE, 10'h155, 2'd0, 0, 1, 16'hFFFF, 1, 16'h0155, 1));
    tbl.push_back(mk("btn_wr_ignored",      4'hE, 10'h155, 2'd0, 1, 0, 16'h0000, 1, 16'h0001, 1));

    foreach (tbl[i]) begin
      buttons = tbl[i].btn; switches = tbl[i].sw;
      bus(tbl[i].addr, tbl[i].re, tbl[i].we, tbl[i].wdata);
      if (tbl[i].chk_rd) chk(tbl[i].name, rdata, tbl[i].exp_rd);
      chk({tbl[i].name, "_irq"}, {15'b0, irq}, {15'b0, tbl[i].exp_irq});
    end

    // Glitch: button 1 low for three cycles only
    buttons = 4'b1100;
    for (int i = 0; i < 3; i++) rd_chk("glitch_low_btn", 2'd0, 16'h0001);
    buttons = 4'b1110;
    for (int i = 0; i < 8; i++) rd_chk("glitch_after_btn", 2'd0, 16'h0001);
    rd_chk("glitch_pend", 2'd2, 16'h0001);

    // Clear pending bit 0; irq drops one edge after the write
    bus(2'd2, 1'b0, 1'b1, 16'h0001);
    chk("w1c0_irq_same_edge", {15'b0, irq}, 16'h0001);
    step();
    chk("w1c0_irq_next_edge", {15'b0, irq}, 16'h0000);
    rd_chk("w1c0_pend", 2'd2, 16'h0000);

    // Button 2 press collides with a W1C of bit 2 at edge 6
    buttons = 4'b1010;
    idle(5);
    bus(2'd2, 1'b0, 1'b1, 16'h0004);
    rd_chk("collide_pend", 2'd2, 16'h0004);
    chk("collide_irq", {15'b0, irq}, 16'h0001);
    rd_chk("collide_btn", 2'd0, 16'h0005);
    bus(2'd2, 1'b0, 1'b1, 16'h0004);
    chk("w1c2_irq_same_edge", {15'b0, irq}, 16'h0001);
    step();
    chk("w1c2_irq_next_edge", {15'b0, irq}, 16'h0000);
    rd_chk("w1c2_pend", 2'd2, 16'h0000);

    // Releases never set pending
    buttons = 4'b1111;
    idle(8);
    rd_chk("release_btn", 2'd0, 16'h0000);
    rd_chk("release_pend", 2'd2, 16'h0000);
    chk("release_irq", {15'b0, irq}, 16'h0000);

    // Reset at edge 4 of a button-3 debounce
    buttons = 4'b0111;
    idle(3);
    reset = 1'b0;
    step();
    chk("midrst_rdata", rdata, 16'h0000);
    chk("midrst_irq", {15'b0, irq}, 16'h0000);
    reset = 1'b1;
    rd_chk("midrst_pend_e5", 2'd2, 16'h0000);
    for (int i = 0; i < 5; i++) rd_chk("midrst_btn_e6_e10", 2'd0, 16'h0000);
    rd_chk("midrst_btn_e11", 2'd0, 16'h0008);
    rd_chk("midrst_pend_e12", 2'd2, 16'h0008);
    chk("midrst_irq_masked", {15'b0, irq}, 16'h0000);
    rd_chk("midrst_mask", 2'd3, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_io_input_ctrl
`default_nettype wire

// File: doc/io_input_ctrl.md
# io_input_ctrl

Parametrised input controller for the CPU environment: synchronises raw slide switches, debounces active-low push buttons, and latches button press events into a sticky pending register with a maskable interrupt. It sits between the board pins (`buttons`, `switches`) and the CPU I/O bus. It replaces direct pin sampling by the CPU, so software reads clean levels and never misses a short press.

## Interface
Parameters:
- `N_BTN`, 4: number of push buttons, 1..16.
- `N_SW`, 10: number of switches, 1..16.
- `DB_CYCLES`, 4: consecutive stable synchronised samples required to accept a button level change, ≥1.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-low; sampled on rising edge of `clk`.
- `buttons`  in  N_BTN: raw buttons, active-low (0 = pressed), asynchronous to `clk`.
- `switches`  in  N_SW: raw switches, active-high, asynchronous.
- `addr`  in  2: register select.
- `re`  in  1: read strobe.
- `we`  in  1: write strobe.
- `wdata`  in  16: write data.
- `rdata`  out  16: registered read data.
- `irq`  out  1: registered interrupt request, level, active-high.

## Operation
- Register map, 16-bit, unused upper bits read 0:
  - 0 BTN_STATE (RO): debounced buttons, 1 = pressed.
  - 1 SW_STATE (RO): synchronised switches.
  - 2 PENDING (R/W1C): bit i set on debounced release→press of button i. Writing 1 clears; writing 0 has no effect.
  - 3 IRQ_MASK (R/W): bits [N_BTN-1:0] writable; upper bits ignored.
- Writes to addresses 0/1 are ignored.
- Synchronisers: two flops per input bit.
- Debounce, per button:
  - counter cleared whenever synced level equals stable level;
  - otherwise counter increments;
  - when the counter equals DB_CYCLES-1 and the level still differs, stable level takes the synced value and the counter clears;
  - counter width $clog2(DB_CYCLES+1).
- Press event: asserted on the same edge stable changes released→pressed. Pending bit sets on that edge.
- Release transitions set nothing.
- Set and W1C of the same bit in the same cycle: set wins, bit stays 1.
- `irq` next value = |(PENDING & IRQ_MASK).
- `re` and `we` in the same cycle:
  - read returns the pre-write value;
  - write takes effect at the same edge.
- `rdata` holds its last value when `re` = 0.

## Timing
- Reset (reset = 0 at an edge) forces:
  - synchroniser flops: buttons 1, switches 0;
  - stable = released;
  - counters 0;
  - PENDING 0;
  - IRQ_MASK 0;
  - `rdata` 0;
  - `irq` 0.
- Reset mid-debounce discards partial counts.
- Reset mid-event drops the event.
- Read latency 1: `re` at edge k, `rdata` valid after edge k+1.
- Press latency, raw level constant from before edge 1:
  - synced after edge 2;
  - BTN_STATE and PENDING update at edge 1+DB_CYCLES+1, which is edge 6 for DB_CYCLES = 4;
  - `irq` rises one edge later.
- Glitch rule: a synced pulse lasting fewer than DB_CYCLES samples never changes stable.
- Switch latency: 2 edges, no debounce.
- `irq` deasserts one edge after the clearing write, or after the mask write that removes the last enabled pending bit.

## Structure
- Shared package `io_pkg`:
  - `IO_DATA_W` = 16;
  - address constants `IO_ADDR_BTN` = 0, `IO_ADDR_SW` = 1, `IO_ADDR_PEND` = 2, `IO_ADDR_MASK` = 3.
- Sub-module `debounce_cell`:
  - parameter `DB_CYCLES`;
  - ports `clk`, `reset`, `din_n`, `level`, `press`;
  - contains the two-flop synchroniser, counter and stable flop;
  - instantiated N_BTN times via generate.
- Top level holds the switch synchronisers, registers, read mux and irq flop.

## Test plan
Run with 60 ns clock, N_BTN = 4, N_SW = 10, DB_CYCLES = 4.
- Reset: hold `reset` = 0 for 2 edges with `buttons` = 4'b1111 → `rdata` = 0, `irq` = 0. A read of addr 0, 2 and 3 each returns 0.
- Clean press: `buttons` = 4'b1110 from edge 1 → BTN_STATE = 0x0001 and PENDING = 0x0001 at edge 6. `irq` stays 0 (mask 0). Write IRQ_MASK = 0x000F → `irq` = 1 one edge after the mask write.
- Glitch: `buttons[1]` low for 3 cycles, then high → BTN_STATE bit 1 never set, PENDING unchanged.
- W1C versus set collision: schedule a write of 0x0004 to addr 2 on the edge where button 2's press registers → PENDING bit 2 reads 1. A later write of 0x0004 clears it, and `irq` falls one edge after.
- Switches: `switches` = 10'b0101010101 → read addr 1 returns 0x0155 within 2+1 edges. Writing 0xFFFF to addr 1 leaves 0x0155.
- Reset mid-debounce: `buttons` = 4'b0111, then `reset` = 0 at edge 4 → after release, BTN_STATE = 0 and PENDING = 0. With the button still held, the press registers DB_CYCLES+2 edges after reset deasserts.
